// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive FIFO block: register offsets inside
// the 4-address window, STATUS bit positions and the default FIFO depth.
// No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Register offsets relative to BASE_ADDRESS
    localparam logic [1:0] STATUS_OFS = 2'd0;
    localparam logic [1:0] DATA_OFS   = 2'd1;
    localparam logic [1:0] LEVEL_OFS  = 2'd2;
    localparam logic [1:0] THRESH_OFS = 2'd3;

    // STATUS register bit indices
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    // Default FIFO depth
    localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Groups the UART receiver feed and the CPU I/O bus of the receive FIFO.
//   rx_byte/rx_strobe/rx_frame_err : from the UART receiver
//   address/din/w_en/r_en          : CPU I/O bus request
//   dout                           : registered I/O read data
//   irq                            : level interrupt (0 unless the IRQ build)
// modport master : the side that drives the receiver feed and the bus
// modport slave  : the FIFO block
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_frame_err;
    logic [7:0] address;
    logic [7:0] din;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic       irq;

    modport master (
        output rx_byte, rx_strobe, rx_frame_err, address, din, w_en, r_en,
        input  dout, irq
    );

    modport slave (
        input  rx_byte, rx_strobe, rx_frame_err, address, din, w_en, r_en,
        output dout, irq
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x 8 storage for the receive FIFO: synchronous write, asynchronous
// read, no reset (contents are don't-care until written).
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Each rx_strobe pushes rx_byte into
// a DEPTH-entry circular FIFO; the CPU drains it over the 8-bit I/O bus.
//   BASE+0 STATUS (R: not_empty/full/overrun/frame_err, W: W1C bits 2,3)
//   BASE+1 DATA   (R: pop)
//   BASE+2 LEVEL  (R: entry count)
//   BASE+3 THRESH (R/W irq threshold; reads 0 without the IRQ build)
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_fifo_if.slave (receiver feed, I/O bus, dout, irq)
// Build option: define UART_RX_FIFO_IRQ_EN for the THRESH register and a
// registered level interrupt; otherwise irq is tied 0.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter logic [7:0] BASE_ADDRESS = 8'h02,
    parameter int         DEPTH        = DEF_DEPTH,
    parameter int         PTR_W        = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             overrun;
    logic             overrun_nxt;
    logic             frame_err;
    logic             frame_err_nxt;
    logic [7:0]       dout_q;
    logic [7:0]       mem_rdata;
    logic [7:0]       status_byte;
    logic [7:0]       thresh_rd;

    logic [7:0]       rel_addr;
    logic             hit;
    logic [1:0]       ofs;
    logic             full;
    logic             not_empty;
    logic             do_pop;
    logic             do_push;
    logic             wr_status;

    // Offset from the base; the top six bits being zero means the
    // address falls inside the 4-register window.
    assign rel_addr  = bus.address - BASE_ADDRESS;
    assign hit       = (rel_addr[7:2] == 6'd0);
    assign ofs       = rel_addr[1:0];

    assign full      = (count == CNT_FULL);
    assign not_empty = (count != '0);
    assign do_pop    = bus.r_en && hit && (ofs == DATA_OFS) && not_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push   = bus.rx_strobe && (!full || do_pop);
    assign wr_status = bus.w_en && hit && (ofs == STATUS_OFS);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_nxt = count - CNT_ONE;
        end
        // Sticky flags: clear first, then set, so a set in the same cycle wins.
        overrun_nxt   = (overrun && !(wr_status && bus.din[ST_OVERRUN]))
                        || (bus.rx_strobe && !do_push);
        frame_err_nxt = (frame_err && !(wr_status && bus.din[ST_FRAME_ERR]))
                        || bus.rx_frame_err;
    end

    always_comb begin
        status_byte               = 8'h00;
        status_byte[ST_NOT_EMPTY] = not_empty;
        status_byte[ST_FULL]      = full;
        status_byte[ST_OVERRUN]   = overrun;
        status_byte[ST_FRAME_ERR] = frame_err;
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (bus.rx_byte),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count     <= count_nxt;
            overrun   <= overrun_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Read data register: updated only by a decoded read, holds otherwise.
    // Reads see the state from before this edge's updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 8'h00;
        end else if (bus.r_en && hit) begin
            case (ofs)
                STATUS_OFS: dout_q <= status_byte;
                DATA_OFS:   dout_q <= not_empty ? mem_rdata : 8'h00;
                LEVEL_OFS:  dout_q <= 8'(count);
                default:    dout_q <= thresh_rd;
            endcase
        end
    end

    assign bus.dout = dout_q;

`ifdef UART_RX_FIFO_IRQ_EN
    logic [7:0] thresh;
    logic [7:0] thresh_nxt;
    logic       irq_q;

    assign thresh_nxt = (bus.w_en && hit && (ofs == THRESH_OFS)) ? bus.din : thresh;

    // irq is evaluated on the values being registered this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh <= 8'h01;
            irq_q  <= 1'b0;
        end else begin
            thresh <= thresh_nxt;
            irq_q  <= ((8'(count_nxt) >= thresh_nxt) && (thresh_nxt != 8'h00))
                      || overrun_nxt || frame_err_nxt;
        end
    end

    assign thresh_rd = thresh;
    assign bus.irq   = irq_q;
`else
    logic unused_din;

    assign unused_din = ^{bus.din[7:4], bus.din[1:0]};
    assign thresh_rd  = 8'h00;
    assign bus.irq    = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each received byte, plus any frame-error pulse, into a DEPTH-entry circular FIFO. The CPU drains the FIFO over the 8-bit memory-mapped I/O bus (address/din/dout/w_en/r_en). This removes the single-byte rx_buffer overrun hazard when CPU service latency exceeds one character time.

Parameters:
BASE_ADDRESS, 8'h02, first I/O address; block decodes BASE..BASE+3
DEPTH, 16, FIFO entries; power of two, 2..128
PTR_W, 4, log2(DEPTH); count register is PTR_W+1 bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  received byte from UART receiver
rx_strobe  input  1  one-cycle pulse, rx_byte valid
rx_frame_err  input  1  one-cycle pulse, stop bit sampled low
address  input  8  I/O bus address
din  input  8  I/O write data
w_en  input  1  I/O write strobe
r_en  input  1  I/O read strobe
dout  output  8  I/O read data, registered
irq  output  1  level interrupt (UART_RX_FIFO_IRQ_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n low): wr_ptr=0, rd_ptr=0, count=0, dout=8'h00, overrun=0, frame_err=0, irq=0, threshold=1. Memory contents are don't-care.
- Register map:
  - BASE+0 STATUS (R): bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky), bits7:4 = 0.
  - BASE+0 STATUS (W): write-1-to-clear on bits 2 and 3. Other bits ignored.
  - BASE+1 DATA (R): pops the FIFO. Writes are ignored.
  - BASE+2 LEVEL (R): count, zero-extended to 8 bits.
  - BASE+3 THRESH (R/W): irq threshold (feature only). Reads 8'h00 without the feature.
- Read latency: dout updates on the clk edge where r_en is sampled with a decoded address. dout holds its value otherwise. Reads to undecoded addresses leave dout unchanged.
- Push: rx_strobe && !full → mem[wr_ptr] <= rx_byte, wr_ptr+1 (wraps modulo DEPTH), count+1.
- Push when full: byte dropped, overrun <= 1, pointers and count unchanged.
- Pop (r_en at BASE+1 and not_empty): dout <= mem[rd_ptr], rd_ptr+1 (wraps), count-1.
- Pop when empty: dout <= 8'h00, no state change, no error flag.
- Simultaneous push+pop, non-empty, not full: both occur, count unchanged.
- Simultaneous push+pop when full: pop occurs, push is accepted into the freed slot, no overrun, count stays DEPTH.
- Simultaneous push+pop when empty: push stored, pop returns 8'h00 (no bypass), count becomes 1.
- rx_frame_err pulse: frame_err <= 1. No byte is pushed.
- Sticky set vs. W1C clear in the same cycle: set wins.
- STATUS read returns flags as they were before that edge's updates.
- full = (count==DEPTH). not_empty = (count!=0). Pointers are PTR_W bits; count is PTR_W+1 bits, so no full/empty ambiguity.

Optional Feature:
Macro UART_RX_FIFO_IRQ_EN.
- Defined: 8-bit THRESH register at BASE+3, written via w_en, reset value 1.
  - irq is registered: irq <= (count >= THRESH && THRESH != 0) || overrun || frame_err, evaluated on post-update values.
  - THRESH=0 disables the level term.
- Undefined: no THRESH register, BASE+3 reads 8'h00, irq constant 0.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets: STATUS_OFS=0, DATA_OFS=1, LEVEL_OFS=2, THRESH_OFS=3
  - status bit indices: ST_NOT_EMPTY=0, ST_FULL=1, ST_OVERRUN=2, ST_FRAME_ERR=3
  - parameter default 16 for DEPTH
- Sub-module uart_fifo_mem: DEPTH x 8 storage, synchronous write, asynchronous read, no reset. Pointer, count and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset, then read BASE+0 and BASE+2 → dout 8'h00 both; irq 0.
- Push 8'h41, 8'h42, 8'h43 via rx_strobe, then three DATA reads → dout 41, 42, 43 on successive edges; STATUS then 8'h00, LEVEL 0.
- Push 17 bytes 8'h00..8'h10 with DEPTH=16 → STATUS 8'h07. Drain reads 00..0F (last byte dropped). STATUS write 8'h04 → overrun cleared.
- With FIFO full, rx_strobe and DATA read in the same cycle → dout = oldest byte, LEVEL stays 16, overrun stays 0. Repeat across pointer wrap.
- DATA read when empty coincident with push of 8'h5A → dout 8'h00, LEVEL 1, next read 8'h5A.
- IRQ build: write THRESH=4, push 3 bytes → irq 0; 4th push → irq 1 one edge later. Pulse rx_frame_err after draining → STATUS bit3 set and irq 1 until STATUS write 8'h08.
